cache_assoc: RTL and testbench
==============================

Name: cache_assoc

Overview:
Parametrised 2-way set-associative, write-back, write-allocate data cache with a per-set LRU replacement bit. It sits between the processor load/store port (32-bit word addressing) and the 128-bit block memory interface. The set count is configurable. Hit/miss performance counters support profiling.

Parameters:
ADDR_WIDTH, 30, processor word-address width; block address is ADDR_WIDTH-2
SET_BITS, 2, log2 of set count (SET_NUM = 2**SET_BITS), legal range 1..6
CNT_WIDTH, 32, width of hit/miss counters

Ports:
clk  input  1  clock, all state on rising edge
proc_reset  input  1  asynchronous active-high reset
proc_read  input  1  load request
proc_write  input  1  store request; wins over proc_read if both are asserted
proc_addr  input  ADDR_WIDTH  word address = {tag, index[SET_BITS], offset[2]}
proc_wdata  input  32  store data
proc_stall  output  1  1 = access not complete; processor holds addr/data/controls
proc_rdata  output  32  load data, valid when proc_stall=0
mem_read  output  1  block fetch request
mem_write  output  1  block write-back request
mem_addr  output  ADDR_WIDTH-2  block address
mem_rdata  input  128  fetched block, word0 = [31:0]
mem_wdata  output  128  write-back block
mem_ready  input  1  memory completion pulse
hit_cnt  output  CNT_WIDTH  completed hit accesses, saturating
miss_cnt  output  CNT_WIDTH  misses detected, saturating

Behaviour:
- Storage per set: 2 ways × {valid, dirty, tag[ADDR_WIDTH-2-SET_BITS], data[128]}, plus lru bit (value = index of least-recently-used way).
- Reset (async): all valid/dirty/tag/data/lru = 0; state IDLE; victim_r=0; mem_ready_r=0; counters 0. Outputs: mem_read=0, mem_write=0, mem_wdata=0, proc_stall=proc_read|proc_write.
- Reset asserted mid-WB/FETCH aborts the transfer immediately. mem_read/mem_write deassert asynchronously. No line is modified.
- mem_ready is registered (mem_ready_r). All transitions on memory completion use mem_ready_r, one cycle after the pulse.
- Hit = valid && tag match in either way of the indexed set. Both ways matching is illegal and cannot arise.
- States: IDLE, WB, FETCH.
- IDLE, no request: stay. proc_stall=0.
- IDLE, hit: proc_stall=0 in the same cycle (zero-wait). proc_rdata = hit-way word[offset] (combinational). On a write hit, the word is merged at the clock edge and dirty is set to 1. lru is set to the other way. hit_cnt is incremented.
- IDLE, miss: proc_stall=1. The victim is the first invalid way (way0 before way1), else the way named by lru; it is latched into victim_r. If the victim is valid and dirty, go to WB, else go to FETCH. miss_cnt is incremented once, on this transition only.
- WB: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ready_r, go to FETCH.
- FETCH: mem_read=1, mem_addr=proc_addr[ADDR_WIDTH-1:2].
- FETCH on mem_ready_r:
  - The victim_r way is written with valid=1 and tag=proc tag.
  - On a read, data=mem_rdata and dirty=0.
  - On a write, data=mem_rdata with proc_wdata merged at offset, and dirty=1.
  - lru is set to the other way. Go to IDLE.
  - The following cycle hits, deasserts stall and counts in hit_cnt.
- Outside WB, mem_wdata=0. Outside WB and FETCH, mem_read=mem_write=0.
- Miss latency without write-back: 1 cycle after the mem_ready pulse, plus 1 cycle hit. With write-back, the WB phase is added.
- Counters saturate at all-ones and do not wrap.
- Only the indexed set is ever written. The other way and other sets are unchanged.

Test Plan (SET_BITS=2; index=addr[3:2], tag=addr[29:4]):
1. Cold read addr 0x10 → mem_read=1, mem_addr=0x04. mem_ready pulse with mem_rdata=0x4444_3333_2222_1111 (word0 = 0x...1111) → stall drops 2 cycles after the pulse, proc_rdata=0x00001111. miss_cnt=1, hit_cnt=1.
2. Read 0x00 then 0x10 (set0, tags 0 and 1) → filled into way0 and way1 with no mem_write. Read 0x00 again → hit, zero-wait, lru=1. Read 0x20 (tag 2) → way1 evicted with no WB. Re-read 0x00 hits; re-read 0x10 misses.
3. Write 0xDEADBEEF to 0x01 on a hit → no stall, line dirty. Force eviction of that way with reads of 0x10 and 0x20 → mem_write=1, mem_addr=0x00, mem_wdata[63:32]=0xDEADBEEF, then FETCH of mem_addr=0x08.
4. Write miss 0x02 data 0xCAFEF00D, mem_rdata all 0xFF → line = {FF.., CAFEF00D, FF..FF}, dirty=1. A subsequent read of 0x02 returns 0xCAFEF00D.
5. Assert proc_reset mid-FETCH → mem_read falls asynchronously; counters 0; a read of a previously cached address misses.
6. Simultaneous proc_read=proc_write=1 on a hit → treated as write (dirty set). hit_cnt increments once per completed access; preloaded hit_cnt=all-ones stays at all-ones.

Source files
------------

// File: rtl/cache_assoc.sv
// -----------------------------------------------------------------------------
// cache_assoc
// 2-way set-associative, write-back, write-allocate data cache. Each set has
// one LRU bit. The processor side uses 32-bit word addresses. The memory side
// moves 128-bit blocks. A hit completes in the same cycle with no wait state.
// A miss may write back a dirty victim, then fetches the missing block.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   proc_reset   asynchronous active-high reset
//   proc_read    load request
//   proc_write   store request; wins over proc_read when both are high
//   proc_addr    word address {tag, index, offset[1:0]}
//   proc_wdata   store data
//   proc_stall   1 while the current access has not completed
//   proc_rdata   load data from the hit way; valid when proc_stall is 0
//   mem_read     block fetch request
//   mem_write    block write-back request
//   mem_addr     block address for mem_read / mem_write
//   mem_rdata    fetched block; word0 is in bits [31:0]
//   mem_wdata    write-back block; zero outside write-back
//   mem_ready    memory completion pulse; registered before use
//   hit_cnt      saturating count of completed hit accesses
//   miss_cnt     saturating count of detected misses
// -----------------------------------------------------------------------------
module cache_assoc #(
   parameter int ADDR_WIDTH = 30,
   parameter int SET_BITS   = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  proc_reset,
   input  logic                  proc_read,
   input  logic                  proc_write,
   input  logic [ADDR_WIDTH-1:0] proc_addr,
   input  logic [31:0]           proc_wdata,
   output logic                  proc_stall,
   output logic [31:0]           proc_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   input  logic [127:0]          mem_rdata,
   output logic [127:0]          mem_wdata,
   input  logic                  mem_ready,
   output logic [CNT_WIDTH-1:0]  hit_cnt,
   output logic [CNT_WIDTH-1:0]  miss_cnt
);

   localparam int SET_NUM = 1 << SET_BITS;
   localparam int TAG_W   = ADDR_WIDTH - 2 - SET_BITS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WB    = 2'd1;
   localparam logic [1:0] ST_FETCH = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Read one 32-bit word out of a block.
   function automatic logic [31:0] get_word(input logic [127:0] line, input logic [1:0] off);
      logic [31:0] w;
      case (off)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         2'd3:    w = line[127:96];
         default: w = line[31:0];
      endcase
      return w;
   endfunction

   // Return a block with one 32-bit word replaced.
   function automatic logic [127:0] put_word(input logic [127:0] line, input logic [1:0] off,
                                             input logic [31:0] w);
      logic [127:0] l;
      l = line;
      case (off)
         2'd0:    l[31:0]   = w;
         2'd1:    l[63:32]  = w;
         2'd2:    l[95:64]  = w;
         2'd3:    l[127:96] = w;
         default: l[31:0]   = w;
      endcase
      return l;
   endfunction

   // Storage: per set, two ways of {valid, dirty, tag, data}, plus the LRU way index.
   logic [1:0]       valid_r [SET_NUM];
   logic [1:0]       dirty_r [SET_NUM];
   logic [TAG_W-1:0] tag_r   [SET_NUM][2];
   logic [127:0]     data_r  [SET_NUM][2];
   logic [SET_NUM-1:0] lru_r;

   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic                 victim_r;
   logic                 mem_ready_r;
   logic [CNT_WIDTH-1:0] hit_cnt_r;
   logic [CNT_WIDTH-1:0] miss_cnt_r;

   logic [SET_BITS-1:0] idx_s;
   logic [TAG_W-1:0]    tag_s;
   logic [1:0]          off_s;
   logic                req_s;
   logic                hit0_s;
   logic                hit1_s;
   logic                hit_s;
   logic                hit_way_s;
   logic                victim_s;
   logic                victim_dirty_s;
   logic                hit_evt_s;
   logic                miss_evt_s;
   logic                fill_s;
   logic [127:0]        fill_data_s;

   assign idx_s = proc_addr[SET_BITS+1:2];
   assign tag_s = proc_addr[ADDR_WIDTH-1:SET_BITS+2];
   assign off_s = proc_addr[1:0];
   assign req_s = proc_read | proc_write;

   assign hit0_s    = valid_r[idx_s][0] && (tag_r[idx_s][0] == tag_s);
   assign hit1_s    = valid_r[idx_s][1] && (tag_r[idx_s][1] == tag_s);
   assign hit_s     = hit0_s | hit1_s;
   assign hit_way_s = hit1_s;

   assign hit_evt_s  = (state_r == ST_IDLE) && req_s && hit_s;
   assign miss_evt_s = (state_r == ST_IDLE) && req_s && !hit_s;
   assign fill_s     = (state_r == ST_FETCH) && mem_ready_r;

   // Victim selection: fill an empty way first (way0 before way1), else evict the LRU way.
   always_comb begin
      victim_s = 1'b0;
      if (!valid_r[idx_s][0]) begin
         victim_s = 1'b0;
      end else if (!valid_r[idx_s][1]) begin
         victim_s = 1'b1;
      end else begin
         victim_s = lru_r[idx_s];
      end
   end

   assign victim_dirty_s = valid_r[idx_s][victim_s] & dirty_r[idx_s][victim_s];

   // A store miss allocates the fetched block with the store word already merged in.
   always_comb begin
      fill_data_s = mem_rdata;
      if (proc_write) begin
         fill_data_s = put_word(mem_rdata, off_s, proc_wdata);
      end else begin
         fill_data_s = mem_rdata;
      end
   end

   // Next-state logic for the miss-handling sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (miss_evt_s) begin
               state_nxt_s = victim_dirty_s ? ST_WB : ST_FETCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WB: begin
            if (mem_ready_r) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_FETCH: begin
            if (mem_ready_r) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Register the memory completion pulse; every completion transition uses this copy.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         mem_ready_r <= 1'b0;
      end else begin
         mem_ready_r <= mem_ready;
      end
   end

   // Sequencer state, and the victim way latched when a miss is detected.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_r  <= ST_IDLE;
         victim_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (miss_evt_s) begin
            victim_r <= victim_s;
         end
      end
   end

   // Line storage: store-hit merge, miss fill, and LRU update (indexed set only).
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         lru_r <= '0;
         for (int s = 0; s < SET_NUM; s++) begin
            valid_r[s] <= 2'b00;
            dirty_r[s] <= 2'b00;
            for (int w = 0; w < 2; w++) begin
               tag_r[s][w]  <= '0;
               data_r[s][w] <= 128'd0;
            end
         end
      end else begin
         if (hit_evt_s) begin
            lru_r[idx_s] <= ~hit_way_s;
            if (proc_write) begin
               data_r[idx_s][hit_way_s]  <= put_word(data_r[idx_s][hit_way_s], off_s, proc_wdata);
               dirty_r[idx_s][hit_way_s] <= 1'b1;
            end
         end else if (fill_s) begin
            valid_r[idx_s][victim_r] <= 1'b1;
            dirty_r[idx_s][victim_r] <= proc_write;
            tag_r[idx_s][victim_r]   <= tag_s;
            data_r[idx_s][victim_r]  <= fill_data_s;
            lru_r[idx_s]             <= ~victim_r;
         end
      end
   end

   // Saturating hit/miss counters.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         hit_cnt_r  <= '0;
         miss_cnt_r <= '0;
      end else begin
         if (hit_evt_s && (hit_cnt_r != CNT_MAX)) begin
            hit_cnt_r <= hit_cnt_r + CNT_ONE;
         end
         if (miss_evt_s && (miss_cnt_r != CNT_MAX)) begin
            miss_cnt_r <= miss_cnt_r + CNT_ONE;
         end
      end
   end

   // Output decode. These are taken from the state register, so reset clears the memory strobes at once.
   always_comb begin
      mem_read   = (state_r == ST_FETCH);
      mem_write  = (state_r == ST_WB);
      mem_wdata  = 128'd0;
      mem_addr   = '0;
      proc_rdata = 32'd0;
      case (state_r)
         ST_WB: begin
            mem_wdata = data_r[idx_s][victim_r];
            mem_addr  = {tag_r[idx_s][victim_r], idx_s};
         end
         ST_FETCH: begin
            mem_addr = proc_addr[ADDR_WIDTH-1:2];
         end
         default: begin
            mem_addr = '0;
         end
      endcase
      if (hit_s) begin
         proc_rdata = get_word(data_r[idx_s][hit_way_s], off_s);
      end else begin
         proc_rdata = 32'd0;
      end
   end

   // The array is all-invalid during reset, so hit_s is 0 and the stall simply follows the request.
   assign proc_stall = req_s & ~((state_r == ST_IDLE) & hit_s);
   assign hit_cnt    = hit_cnt_r;
   assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_cache_assoc.sv
// -----------------------------------------------------------------------------
// tb_cache_assoc
// Drives cache_assoc with directed and random accesses. Each result is compared
// with a reference model of the cache held in this bench. The model keeps each
// line as a record, tracks the most-recently-used way, and keeps a sparse
// backing memory.
// -----------------------------------------------------------------------------
module tb_cache_assoc;

   logic         clk;
   logic         proc_reset;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_rdata;
   logic [127:0] mem_wdata;
   logic         mem_ready;
   logic [7:0]   hit_cnt;
   logic [7:0]   miss_cnt;

   cache_assoc #(.ADDR_WIDTH(30), .SET_BITS(2), .CNT_WIDTH(8)) dut (
      .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
      .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
      .proc_rdata(proc_rdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           valid;
      bit           dirty;
      logic [25:0]  tag;
      logic [127:0] data;
   } line_t;

   line_t        m_line [4][2];
   int           m_mru  [4];
   int           m_hits;
   int           m_miss;
   logic [127:0] mem_model [logic [27:0]];

   int n_vec;
   int n_err;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] merge(input logic [127:0] d, input int off, input logic [31:0] w);
      logic [127:0] r;
      r = d;
      r[off*32 +: 32] = w;
      return r;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         m_mru[s] = 1;
         for (int w = 0; w < 2; w++) begin
            m_line[s][w].valid = 1'b0;
            m_line[s][w].dirty = 1'b0;
            m_line[s][w].tag   = '0;
            m_line[s][w].data  = '0;
         end
      end
      m_hits = 0;
      m_miss = 0;
   endtask

   // One complete processor access, including any write-back and fetch.
   task automatic access(input bit rd, input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                         output bit was_hit, output bit did_wb,
                         output logic [27:0] wb_addr, output logic [127:0] wb_data);
      int          set;
      int          off;
      int          way;
      int          k;
      logic [25:0] tag;
      logic [27:0] blk;
      set = int'(addr[3:2]);
      off = int'(addr[1:0]);
      tag = addr[29:4];
      blk = addr[29:2];
      did_wb  = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      way = -1;
      for (int w = 0; w < 2; w++) begin
         if (m_line[set][w].valid && m_line[set][w].tag == tag) way = w;
      end
      was_hit = (way >= 0);

      @(negedge clk);
      proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
      #1;
      if (was_hit) begin
         chk("hit_stall", proc_stall, 1'b0);
         chk("hit_no_mem", {mem_read, mem_write}, 2'b00);
      end else begin
         chk("miss_stall", proc_stall, 1'b1);
         if (!m_line[set][0].valid) way = 0;
         else if (!m_line[set][1].valid) way = 1;
         else way = 1 - m_mru[set];
         did_wb = m_line[set][way].valid && m_line[set][way].dirty;
         m_miss = sat_inc(m_miss);
         @(negedge clk);
         if (did_wb) begin
            wb_addr = {m_line[set][way].tag, addr[3:2]};
            wb_data = m_line[set][way].data;
            chk("wb_strobes", {mem_write, mem_read}, 2'b10);
            chk("wb_addr", mem_addr, wb_addr);
            chk("wb_data", mem_wdata, wb_data);
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin
               @(negedge clk);
               chk("wb_hold", mem_write, 1'b1);
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            chk("wb_until_ready_r", mem_write, 1'b1);
            mem_model[wb_addr] = wb_data;
            @(negedge clk);
         end
         chk("fetch_strobes", {mem_write, mem_read}, 2'b01);
         chk("fetch_addr", mem_addr, blk);
         chk("fetch_wdata_zero", mem_wdata, 128'd0);
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("fetch_hold", proc_stall, 1'b1);
         end
         if (!mem_model.exists(blk)) mem_model[blk] = {$urandom, $urandom, $urandom, $urandom};
         mem_rdata = mem_model[blk];
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         chk("fetch_stall_after_pulse", proc_stall, 1'b1);
         @(negedge clk);
         m_line[set][way].valid = 1'b1;
         m_line[set][way].tag   = tag;
         m_line[set][way].data  = wr ? merge(mem_model[blk], off, wd) : mem_model[blk];
         m_line[set][way].dirty = wr;
         m_mru[set] = way;
         chk("fill_stall_low", proc_stall, 1'b0);
         chk("fill_mem_idle", {mem_read, mem_write}, 2'b00);
      end
      if (rd && !wr) chk("rdata", proc_rdata, m_line[set][way].data[off*32 +: 32]);
      @(posedge clk);
      if (wr) begin
         m_line[set][way].data  = merge(m_line[set][way].data, off, wd);
         m_line[set][way].dirty = 1'b1;
      end
      m_mru[set] = way;
      m_hits = sat_inc(m_hits);
      #1;
      chk("hit_cnt", hit_cnt, m_hits[7:0]);
      chk("miss_cnt", miss_cnt, m_miss[7:0]);
      @(negedge clk);
      proc_read = 1'b0; proc_write = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      proc_reset = 1'b1;
      #1;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_mem_wdata", mem_wdata, 128'd0);
      chk("rst_hit_cnt", hit_cnt, 8'd0);
      chk("rst_miss_cnt", miss_cnt, 8'd0);
      chk("rst_stall_idle", proc_stall, 1'b0);
      proc_read = 1'b1;
      #1;
      chk("rst_stall_req", proc_stall, 1'b1);
      proc_read = 1'b0;
      @(negedge clk);
      proc_reset = 1'b0;
      model_reset();
   endtask

   bit           h;
   bit           w;
   logic [27:0]  wa;
   logic [127:0] wdt;

   initial begin
      n_vec = 0; n_err = 0;
      proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
      proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
      model_reset();
      do_reset();

      // Cold read miss, 0x10 -> block 0x04
      mem_model[28'h4] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
      access(1, 0, 30'h10, 32'd0, h, w, wa, wdt);
      chk("t1_miss", h, 1'b0);
      chk("t1_miss_cnt", miss_cnt, 8'd1);
      chk("t1_hit_cnt", hit_cnt, 8'd1);

      // Fill both ways of set0, then replacement by LRU
      do_reset();
      access(1, 0, 30'h00, 32'd0, h, w, wa, wdt); chk("t2_a_miss", h, 1'b0);
      access(1, 0, 30'h10, 32'd0, h, w, wa, wdt); chk("t2_b_miss", h, 1'b0); chk("t2_b_nowb", w, 1'b0);
      access(1, 0, 30'h00, 32'd0, h, w, wa, wdt); chk("t2_a_hit", h, 1'b1);
      access(1, 0, 30'h20, 32'd0, h, w, wa, wdt); chk("t2_c_miss", h, 1'b0); chk("t2_c_nowb", w, 1'b0);
      access(1, 0, 30'h00, 32'd0, h, w, wa, wdt); chk("t2_a_rehit", h, 1'b1);
      access(1, 0, 30'h10, 32'd0, h, w, wa, wdt); chk("t2_b_remiss", h, 1'b0);

      // Store hit then dirty eviction
      access(0, 1, 30'h01, 32'hDEADBEEF, h, w, wa, wdt); chk("t3_wr_hit", h, 1'b1);
      access(1, 0, 30'h10, 32'd0, h, w, wa, wdt); chk("t3_b_hit", h, 1'b1);
      access(1, 0, 30'h20, 32'd0, h, w, wa, wdt);
      chk("t3_wb", w, 1'b1);
      chk("t3_wb_addr", wa, 28'h0);
      chk("t3_wb_word1", wdt[63:32], 32'hDEADBEEF);

      // Store miss with write-allocate
      mem_model[28'h0] = {128{1'b1}};
      access(0, 1, 30'h02, 32'hCAFEF00D, h, w, wa, wdt); chk("t4_wr_miss", h, 1'b0); chk("t4_nowb", w, 1'b0);
      access(1, 0, 30'h02, 32'd0, h, w, wa, wdt); chk("t4_rd_hit", h, 1'b1);
      access(1, 0, 30'h00, 32'd0, h, w, wa, wdt); chk("t4_rd_w0_hit", h, 1'b1);

      // Reset in the middle of a fetch
      @(negedge clk);
      proc_read = 1'b1; proc_addr = 30'h40;
      #1;
      chk("t5_stall", proc_stall, 1'b1);
      @(negedge clk);
      chk("t5_in_fetch", mem_read, 1'b1);
      #1;
      proc_reset = 1'b1;
      #1;
      chk("t5_mem_read_async", mem_read, 1'b0);
      chk("t5_hit_cnt", hit_cnt, 8'd0);
      chk("t5_miss_cnt", miss_cnt, 8'd0);
      chk("t5_stall_rst", proc_stall, 1'b1);
      @(negedge clk);
      proc_read = 1'b0; proc_reset = 1'b0;
      model_reset();
      access(1, 0, 30'h02, 32'd0, h, w, wa, wdt); chk("t5_cached_lost", h, 1'b0);

      // Read and write together act as a write; hit counter saturation
      access(1, 1, 30'h02, 32'h12345678, h, w, wa, wdt); chk("t6_rw_hit", h, 1'b1);
      access(1, 0, 30'h10, 32'd0, h, w, wa, wdt); chk("t6_b_miss", h, 1'b0);
      access(1, 0, 30'h20, 32'd0, h, w, wa, wdt);
      chk("t6_wb", w, 1'b1);
      chk("t6_wb_addr", wa, 28'h0);
      chk("t6_wb_word2", wdt[95:64], 32'h12345678);
      for (int i = 0; i < 260; i++) begin
         access(1, 0, 30'h20, 32'd0, h, w, wa, wdt);
      end
      chk("t6_hit_sat", hit_cnt, 8'hFF);
      access(1, 1, 30'h20, 32'h0BADF00D, h, w, wa, wdt);
      chk("t6_hit_sat_hold", hit_cnt, 8'hFF);

      // Random traffic against the reference model
      do_reset();
      for (int i = 0; i < 250; i++) begin
         int          op;
         logic [29:0] a;
         op = $urandom_range(0, 2);
         a  = '0;
         a[5:4] = 2'($urandom_range(0, 3));
         a[3:0] = 4'($urandom_range(0, 15));
         access(op != 1, op != 0, a, $urandom, h, w, wa, wdt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
